// File: rtl/uart_pkg.sv
// Shared UART RX constants: default frame/prescale widths and bit-order encodings.
package uart_pkg;

  localparam int UART_DATA_WIDTH     = 8;
  localparam int UART_PRESCALE_WIDTH = 6;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/deserializer_cfg.sv
// UART RX deserializer: collects 1..DATA_WIDTH sampled bits, LSB/MSB first, into a right-justified word.
// Latency: P_DATA/P_DATA_VLD one CLK after the final sampling tick; VLD is a single-cycle strobe.
// No backpressure: consumer must take P_DATA on the VLD strobe; deser_en low aborts a partial frame.
module deserializer_cfg
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter  int PRESCALE_WIDTH = UART_PRESCALE_WIDTH,
  localparam int CNT_WIDTH      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      deser_en,
  input  logic                      sampled_bit,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [CNT_WIDTH-1:0]      data_len,
  input  logic                      msb_first,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      P_DATA_VLD,
  output logic                      busy
);

  logic [CNT_WIDTH-1:0]      bit_cnt;
  logic [CNT_WIDTH-1:0]      len_q;
  logic                      order_q;
  logic [DATA_WIDTH-1:0]     sreg;

  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic                      tick;
  logic                      first;
  logic                      done;
  logic                      cur_order;
  logic [CNT_WIDTH-1:0]      eff_len;
  logic [CNT_WIDTH-1:0]      cur_len;
  logic [CNT_WIDTH-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0]     base;
  logic [DATA_WIDTH-1:0]     next_sreg;

  // Prescale of 0 wraps to all-ones, so edge 2^W-1 becomes the sampling point.
  assign last_edge = Prescale - PRESCALE_WIDTH'(1);
  assign tick      = deser_en && (edge_cnt == last_edge);
  assign busy      = (bit_cnt != '0);

  always_comb begin
    eff_len = data_len;
    if ((data_len == '0) || (data_len > CNT_WIDTH'(DATA_WIDTH)))
      eff_len = CNT_WIDTH'(DATA_WIDTH);

    // On the first tick the live config applies; afterwards the latched copy does.
    first     = (bit_cnt == '0);
    cur_len   = first ? eff_len   : len_q;
    cur_order = first ? msb_first : order_q;
    base      = first ? '0        : sreg;

    next_sreg = base;
    if (cur_order == MSB_FIRST) begin
      next_sreg = {base[DATA_WIDTH-2:0], sampled_bit};
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++)
        if (CNT_WIDTH'(i) == bit_cnt) next_sreg[i] = sampled_bit;
    end

    cnt_inc = bit_cnt + CNT_WIDTH'(1);
    done    = tick && (cnt_inc == cur_len);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt <= '0;
      len_q   <= '0;
      order_q <= LSB_FIRST;
      sreg    <= '0;
    end else if (!deser_en) begin
      bit_cnt <= '0;
    end else if (tick) begin
      sreg    <= next_sreg;
      bit_cnt <= done ? '0 : cnt_inc;
      if (first) begin
        len_q   <= eff_len;
        order_q <= msb_first;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA     <= '0;
      P_DATA_VLD <= 1'b0;
    end else begin
      P_DATA_VLD <= done;
      if (done) P_DATA <= next_sreg;
    end
  end

endmodule

// File: tb/tb_deserializer_cfg.sv
// Directed + randomized bench for deserializer_cfg against a bit-list reference model.
module tb_deserializer_cfg;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int CW = $clog2(DW + 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          deser_en;
  logic          sampled_bit;
  logic [PW-1:0] edge_cnt;
  logic [PW-1:0] Prescale;
  logic [CW-1:0] data_len;
  logic          msb_first;
  logic [DW-1:0] P_DATA;
  logic          P_DATA_VLD;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] vld_q[$];

  deserializer_cfg #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
    .edge_cnt(edge_cnt), .Prescale(Prescale), .data_len(data_len), .msb_first(msb_first),
    .P_DATA(P_DATA), .P_DATA_VLD(P_DATA_VLD), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Every cycle with VLD high is logged, so a stretched strobe shows up as an extra word.
  always @(posedge CLK) begin
    #1;
    if (P_DATA_VLD === 1'b1) vld_q.push_back(P_DATA);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    deser_en = 1'b0;
    edge_cnt = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Bits are given in arrival order: bits[0] is received first.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] bits, input int n, input logic msb);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      if (msb) w = (w << 1) | DW'(bits[i]);
      else     w = w | (DW'(bits[i]) << i);
    end
    return w;
  endfunction

  function automatic int eff_len_of(input int len);
    return (len == 0 || len > DW) ? DW : len;
  endfunction

  task automatic send_bit(input logic b, input int period, input bit fast);
    if (fast) begin
      edge_cnt    = PW'(period - 1);
      sampled_bit = b;
      step();
    end else begin
      for (int e = 0; e < period; e++) begin
        edge_cnt    = PW'(e);
        sampled_bit = (e == period - 1) ? b : 1'($urandom);
        step();
      end
    end
  endtask

  // alt_len/alt_msb are applied after the first bit to show mid-frame changes are ignored.
  task automatic send_frame(input logic [DW-1:0] bits, input int n, input int len, input logic msb,
                            input int alt_len, input logic alt_msb, input logic [PW-1:0] ps,
                            input bit fast, input bit keep);
    int period;
    period    = (ps == 0) ? (1 << PW) : int'(ps);
    deser_en  = 1'b1;
    data_len  = CW'(len);
    msb_first = msb;
    Prescale  = ps;
    for (int i = 0; i < n; i++) begin
      send_bit(bits[i], period, fast);
      if (i == 0) begin
        data_len  = CW'(alt_len);
        msb_first = alt_msb;
      end
    end
    if (!keep) begin
      deser_en = 1'b0;
      edge_cnt = '0;
    end
  endtask

  task automatic expect_words(input string tag, input int n, input logic [DW-1:0] w0,
                              input logic [DW-1:0] w1);
    logic [DW-1:0] exp_w[2];
    exp_w[0] = w0;
    exp_w[1] = w1;
    chk({tag, "_vld_count"}, 32'(vld_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < vld_q.size()) chk({tag, "_word"}, 32'(vld_q[i]), 32'(exp_w[i]));
    vld_q.delete();
  endtask

  initial begin
    logic [DW-1:0] bits;
    int            len, alt, n, psel;
    logic          msb, fast;
    logic [PW-1:0] ps;

    RST = 1'b1; deser_en = 1'b0; sampled_bit = 1'b0; edge_cnt = '0;
    Prescale = PW'(8); data_len = CW'(8); msb_first = LSB_FIRST;
    #1;
    chk("reset_pdata", 32'(P_DATA), 0);
    chk("reset_vld",   32'(P_DATA_VLD), 0);
    chk("reset_busy",  32'(busy), 0);
    step(); step();
    RST = 1'b0;
    idle(2);
    vld_q.delete();

    // Stream 1,0,1,1,0,0,1,0 in arrival order.
    bits = 8'b0100_1101;
    send_frame(bits, 8, 8, LSB_FIRST, 8, LSB_FIRST, PW'(8), 1'b0, 1'b0);
    idle(3);
    expect_words("lsb8", 1, 8'h4D, 8'h00);

    send_frame(bits, 8, 8, MSB_FIRST, 8, MSB_FIRST, PW'(8), 1'b0, 1'b0);
    idle(3);
    expect_words("msb8", 1, 8'hB2, 8'h00);

    // Reset lands mid-frame after three ticks.
    send_frame(8'b0000_0111, 3, 8, LSB_FIRST, 8, LSB_FIRST, PW'(8), 1'b0, 1'b1);
    chk("pre_reset_busy", 32'(busy), 1);
    RST = 1'b1;
    #1;
    chk("rst_pdata", 32'(P_DATA), 0);
    chk("rst_vld",   32'(P_DATA_VLD), 0);
    chk("rst_busy",  32'(busy), 0);
    deser_en = 1'b0;
    step();
    RST = 1'b0;
    idle(2);
    vld_q.delete();

    // 1,1,0,0,1 with data_len switched to 7 after the first bit.
    send_frame(8'b0001_0011, 5, 5, LSB_FIRST, 7, MSB_FIRST, PW'(8), 1'b0, 1'b0);
    idle(3);
    expect_words("len5", 1, 8'h13, 8'h00);

    send_frame(8'b1111_0000, 4, 8, LSB_FIRST, 8, LSB_FIRST, PW'(8), 1'b0, 1'b1);
    chk("abort_busy_before", 32'(busy), 1);
    deser_en = 1'b0;
    step();
    chk("abort_busy_after", 32'(busy), 0);
    idle(3);
    expect_words("abort", 0, 8'h00, 8'h00);
    chk("abort_pdata_held", 32'(P_DATA), 32'h13);

    // Second frame's first tick falls in the cycle right after the first completes.
    send_frame(8'hA5, 8, 8, LSB_FIRST, 8, LSB_FIRST, PW'(8), 1'b1, 1'b1);
    send_frame(8'h3C, 8, 8, LSB_FIRST, 8, LSB_FIRST, PW'(8), 1'b1, 1'b0);
    idle(3);
    expect_words("b2b", 2, 8'hA5, 8'h3C);

    for (int f = 0; f < 24; f++) begin
      bits = DW'($urandom);
      len  = $urandom_range(0, (1 << CW) - 1);
      alt  = $urandom_range(0, (1 << CW) - 1);
      msb  = 1'($urandom);
      fast = 1'($urandom);
      psel = $urandom_range(0, 3);
      ps   = (psel == 0) ? PW'(8) : (psel == 1) ? PW'(16) : (psel == 2) ? PW'(32) : PW'(0);
      n    = eff_len_of(len);
      send_frame(bits, n, len, msb, alt, ~msb, ps, fast, 1'b0);
      idle(2);
      expect_words("rand", 1, model(bits, n, msb), 8'h00);
      chk("rand_busy_idle", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
